pak_coeff_loader: RTL and testbench

- Memory-interface initiator that drives the pak_dsp coefficient memory port (addr, write_en, wdata, rdata); pak_dsp is the responder on that port.
- Accepts N coefficients on a valid/ready stream and writes them to consecutive addresses from BASE_ADDR.
- Optionally reads the block back and counts mismatches against a local shadow copy.
- Sits between the host/config path and pak_dsp's read/write memory interface.

---
 rtl/pak_coeff_loader.sv | 140 ++++++++++++++
 tb/tb_pak_coeff_loader.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pak_coeff_loader.sv
// Coefficient loader: streams N coefficients into pak_dsp's coefficient memory
// starting at BASE_ADDR, with an optional readback against a local shadow copy.
module pak_coeff_loader #(
    parameter int COEFF_WIDTH = 16,
    parameter int N           = 4,
    parameter int ADDR_WIDTH  = 8,
    parameter int BASE_ADDR   = 0
) (
    input  logic                       clk,
    input  logic                       arst_n,
    input  logic                       start,
    input  logic                       verify_en,
    input  logic [COEFF_WIDTH-1:0]     coeff_in,
    input  logic                       coeff_valid_in,
    output logic                       coeff_ready_out,
    output logic [ADDR_WIDTH-1:0]      addr,
    output logic                       write_en,
    output logic [COEFF_WIDTH-1:0]     wdata,
    input  logic [COEFF_WIDTH-1:0]     rdata,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(N+1)-1:0]     mismatch_cnt,
    output logic                       error
);

    // state   | meaning
    // IDLE    | waiting for start
    // WRITE   | accepting coefficients, one memory write per handshake
    // READ    | presenting readback addresses BASE_ADDR..BASE_ADDR+N-1
    // DRAIN   | last readback data still in flight
    // DONE    | completion; done pulses in the following cycle

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(N + 1);
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0]      CNT_MAX  = CNT_W'(N);
    localparam logic [ADDR_WIDTH-1:0] BASE     = ADDR_WIDTH'(BASE_ADDR);

    if (longint'(BASE_ADDR) + longint'(N) - 1 >= (longint'(1) << ADDR_WIDTH)) begin : g_addr_range_check
        $error("pak_coeff_loader: coefficient block does not fit in the address space");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [IDX_W-1:0]       idx;
    logic [IDX_W-1:0]       ridx;
    logic                   verify_q;
    logic [COEFF_WIDTH-1:0] shadow [N];
    logic                   rd_v1, rd_v2;
    logic [IDX_W-1:0]       rd_idx1, rd_idx2;
    logic                   hs;

    assign coeff_ready_out = (state == S_WRITE);
    assign hs              = coeff_ready_out && coeff_valid_in;
    // busy stays up through the done pulse so a host never sees idle before completion
    assign busy            = (state != S_IDLE) || done;
    assign error           = (mismatch_cnt != '0);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_WRITE;
            S_WRITE: if (hs && idx == LAST_IDX) state_nxt = verify_q ? S_READ : S_DONE;
            S_READ:  if (ridx == LAST_IDX) state_nxt = S_DRAIN;
            S_DRAIN: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            idx          <= '0;
            ridx         <= '0;
            verify_q     <= 1'b0;
            addr         <= '0;
            write_en     <= 1'b0;
            wdata        <= '0;
            done         <= 1'b0;
            mismatch_cnt <= '0;
            rd_v1        <= 1'b0;
            rd_v2        <= 1'b0;
            rd_idx1      <= '0;
            rd_idx2      <= '0;
            for (int i = 0; i < N; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            write_en <= 1'b0;
            done     <= (state == S_DONE);
            rd_v1    <= 1'b0;
            rd_v2    <= rd_v1;
            rd_idx2  <= rd_idx1;

            if (hs) begin
                shadow[idx] <= coeff_in;
                addr        <= BASE + ADDR_WIDTH'(idx);
                wdata       <= coeff_in;
                write_en    <= 1'b1;
                idx         <= idx + 1'b1;
            end

            if (state == S_READ) begin
                addr    <= BASE + ADDR_WIDTH'(ridx);
                rd_v1   <= 1'b1;
                rd_idx1 <= ridx;
                ridx    <= ridx + 1'b1;
            end

            // rd_v2 marks the cycle in which rdata belongs to rd_idx2
            if (rd_v2 && rdata != shadow[rd_idx2] && mismatch_cnt != CNT_MAX) begin
                mismatch_cnt <= mismatch_cnt + 1'b1;
            end

            if (state == S_IDLE && start) begin
                verify_q     <= verify_en;
                mismatch_cnt <= '0;
                idx          <= '0;
                ridx         <= '0;
            end
        end
    end

endmodule

// File: tb/tb_pak_coeff_loader.sv
// Self-checking bench for pak_coeff_loader: directed scenarios plus randomized
// loads checked against a cycle-level expectation derived from the stream handshakes.
module tb_pak_coeff_loader;

    localparam int CW   = 16;
    localparam int N    = 4;
    localparam int AW   = 8;
    localparam int CNTW = 3;
    localparam int WIN  = 64;

    logic            clk;
    logic            arst_n;
    logic            start;
    logic            verify_en;
    logic [CW-1:0]   coeff_in;
    logic            coeff_valid_in;
    logic            coeff_ready_out;
    logic [AW-1:0]   addr;
    logic            write_en;
    logic [CW-1:0]   wdata;
    logic [CW-1:0]   rdata;
    logic            busy;
    logic            done;
    logic [CNTW-1:0] mismatch_cnt;
    logic            error;

    pak_coeff_loader #(.COEFF_WIDTH(CW), .N(N), .ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .arst_n(arst_n), .start(start), .verify_en(verify_en),
        .coeff_in(coeff_in), .coeff_valid_in(coeff_valid_in), .coeff_ready_out(coeff_ready_out),
        .addr(addr), .write_en(write_en), .wdata(wdata), .rdata(rdata),
        .busy(busy), .done(done), .mismatch_cnt(mismatch_cnt), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // memory responder: 1-cycle read latency; corrupt[] addresses read back as zero
    logic [CW-1:0] mem [256];
    logic [N-1:0]  corrupt;
    always @(posedge clk) begin
        if (write_en) mem[addr] <= wdata;
        else rdata <= (addr < AW'(N) && corrupt[addr[1:0]]) ? '0 : mem[addr];
    end

    // per-cycle snapshots relative to the start cycle
    int            start_cyc;
    bit            mon_on;
    logic          snap_we   [WIN];
    logic [AW-1:0] snap_addr [WIN];
    logic [CW-1:0] snap_wdata[WIN];
    logic          snap_done [WIN];
    logic          snap_busy [WIN];
    logic          snap_err  [WIN];
    logic [CNTW-1:0] snap_mm [WIN];

    always @(negedge clk) begin
        if (mon_on && (cyc - start_cyc) >= 0 && (cyc - start_cyc) < WIN) begin
            snap_we   [cyc - start_cyc] <= write_en;
            snap_addr [cyc - start_cyc] <= addr;
            snap_wdata[cyc - start_cyc] <= wdata;
            snap_done [cyc - start_cyc] <= done;
            snap_busy [cyc - start_cyc] <= busy;
            snap_err  [cyc - start_cyc] <= error;
            snap_mm   [cyc - start_cyc] <= mismatch_cnt;
        end
    end

    logic [CW-1:0] ld_data [N];
    int            hs_rel  [N];

    task automatic clear_snaps();
        for (int i = 0; i < WIN; i++) begin
            snap_we[i] = 0; snap_addr[i] = 0; snap_wdata[i] = 0; snap_done[i] = 0;
            snap_busy[i] = 0; snap_err[i] = 0; snap_mm[i] = 0;
        end
    endtask

    task automatic run_load(input bit v, input int gap_after, input int gap_len, input int restart_at);
        int  b, guard, gap_left, g;
        bit  hs, restarted;
        clear_snaps();
        @(posedge clk); #1;
        start = 1; verify_en = v; start_cyc = cyc; mon_on = 1;
        @(posedge clk); #1;
        start = 0; verify_en = 0;
        b = 0; guard = 0; gap_left = 0; restarted = 0;
        while (b < N && guard < 100) begin
            guard++;
            if (gap_left > 0) begin
                coeff_valid_in = 0; gap_left--;
            end else begin
                coeff_valid_in = 1; coeff_in = ld_data[b];
            end
            if (b == restart_at && !restarted) begin
                start = 1; verify_en = ~v; restarted = 1;
            end
            hs = coeff_valid_in && coeff_ready_out;
            if (hs) hs_rel[b] = cyc - start_cyc;
            @(posedge clk); #1;
            start = 0; verify_en = 0;
            if (hs) begin
                b++;
                if (b == gap_after && gap_len > 0) gap_left = gap_len;
            end
        end
        coeff_valid_in = 0;
        checks++;
        if (b != N) begin
            errors++;
            $display("FAIL stream_timeout: accepted %0d beats, required %0d", b, N);
        end
        g = 0;
        while (!done && g < 40) begin
            @(posedge clk); #1; g++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, g);
        end
        repeat (3) begin @(posedge clk); #1; end
        mon_on = 0;
    endtask

    // expectations: write k one cycle after handshake k; readback follows the last write,
    // done one cycle after the last write (no verify) or six cycles after it (verify)
    task automatic check_load(input bit v, input int exp_mm);
        int last, exp_done, nw, nd;
        last = hs_rel[N-1] + 1;
        exp_done = v ? last + 6 : last + 1;
        nw = 0; nd = 0;
        for (int r = 0; r < WIN; r++) begin
            if (snap_we[r] === 1'b1) nw++;
            if (snap_done[r] === 1'b1) nd++;
        end
        checks++;
        if (nw != N) begin errors++; $display("FAIL write_count: got %0d required %0d", nw, N); end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (snap_we[hs_rel[k]+1] !== 1'b1 || snap_addr[hs_rel[k]+1] !== AW'(k) ||
                snap_wdata[hs_rel[k]+1] !== ld_data[k]) begin
                errors++;
                $display("FAIL write[%0d] at cycle %0d: we=%0b addr=%0h wdata=%0h, required we=1 addr=%0h wdata=%0h",
                         k, hs_rel[k]+1, snap_we[hs_rel[k]+1], snap_addr[hs_rel[k]+1],
                         snap_wdata[hs_rel[k]+1], k, ld_data[k]);
            end
            if (v) begin
                checks++;
                if (snap_we[last+1+k] !== 1'b0 || snap_addr[last+1+k] !== AW'(k)) begin
                    errors++;
                    $display("FAIL read[%0d] at cycle %0d: we=%0b addr=%0h, required we=0 addr=%0h",
                             k, last+1+k, snap_we[last+1+k], snap_addr[last+1+k], k);
                end
            end
        end
        checks++;
        if (nd != 1 || snap_done[exp_done] !== 1'b1) begin
            errors++;
            $display("FAIL done_pulse: %0d pulses, done at cycle %0d = %0b, required one pulse at that cycle",
                     nd, exp_done, snap_done[exp_done]);
        end
        checks++;
        if (snap_busy[exp_done] !== 1'b1 || snap_busy[exp_done+1] !== 1'b0) begin
            errors++;
            $display("FAIL busy_end: busy at done=%0b after=%0b, required 1 then 0",
                     snap_busy[exp_done], snap_busy[exp_done+1]);
        end
        checks++;
        if (snap_mm[exp_done] !== CNTW'(exp_mm) || snap_err[exp_done] !== (exp_mm != 0)) begin
            errors++;
            $display("FAIL mismatch: cnt=%0d error=%0b, required cnt=%0d error=%0b",
                     snap_mm[exp_done], snap_err[exp_done], exp_mm, exp_mm != 0);
        end
    endtask

    function automatic int model_mismatch(input bit v);
        int m = 0;
        if (v) for (int k = 0; k < N; k++) if (corrupt[k] && ld_data[k] != '0) m++;
        return (m > N) ? N : m;
    endfunction

    task automatic set_plan_data();
        ld_data[0] = 16'h0001; ld_data[1] = 16'h7FFF; ld_data[2] = 16'h8000; ld_data[3] = 16'h1234;
    endtask

    task automatic test_reset();
        arst_n = 0; start = 0; verify_en = 0; coeff_in = 0; coeff_valid_in = 0; corrupt = 0; mon_on = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({write_en, busy, done, coeff_ready_out, error} !== 5'b0 || addr !== '0 ||
            wdata !== '0 || mismatch_cnt !== '0) begin
            errors++;
            $display("FAIL reset_state: we=%0b busy=%0b done=%0b rdy=%0b err=%0b addr=%0h wdata=%0h mm=%0d, required all zero",
                     write_en, busy, done, coeff_ready_out, error, addr, wdata, mismatch_cnt);
        end
        arst_n = 1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || coeff_ready_out !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: busy=%0b rdy=%0b, required 0 0", busy, coeff_ready_out);
        end
    endtask

    task automatic test_back_to_back();
        set_plan_data(); corrupt = 0;
        run_load(0, 0, 0, -1);
        check_load(0, 0);
        checks++;
        if (snap_we[2] !== 1'b1 || snap_we[5] !== 1'b1 || snap_done[6] !== 1'b1 || snap_busy[7] !== 1'b0) begin
            errors++;
            $display("FAIL plan_timing: we2=%0b we5=%0b done6=%0b busy7=%0b, required 1 1 1 0",
                     snap_we[2], snap_we[5], snap_done[6], snap_busy[7]);
        end
    endtask

    task automatic test_gap();
        set_plan_data(); corrupt = 0;
        run_load(0, 2, 3, -1);
        check_load(0, 0);
    endtask

    task automatic test_verify();
        set_plan_data(); corrupt = 0;
        run_load(1, 0, 0, -1);
        check_load(1, 0);
        checks++;
        if (snap_done[11] !== 1'b1) begin
            errors++;
            $display("FAIL verify_done_cycle: done at 11 = %0b, required 1", snap_done[11]);
        end
    endtask

    task automatic test_corrupt();
        set_plan_data(); corrupt = 4'b0100;
        run_load(1, 0, 0, -1);
        check_load(1, 1);
        corrupt = 0;
        run_load(0, 0, 0, -1);
        checks++;
        if (snap_mm[1] !== '0 || snap_err[1] !== 1'b0) begin
            errors++;
            $display("FAIL mismatch_clear: cnt=%0d err=%0b after new start, required 0 0", snap_mm[1], snap_err[1]);
        end
        check_load(0, 0);
    endtask

    task automatic test_restart_ignored();
        set_plan_data(); corrupt = 0;
        run_load(0, 0, 0, 2);
        check_load(0, 0);
    endtask

    task automatic test_reset_midload();
        int nw;
        set_plan_data();
        @(posedge clk); #1;
        start = 1; verify_en = 0; start_cyc = cyc;
        @(posedge clk); #1;
        start = 0;
        for (int b = 0; b < 3; b++) begin
            coeff_valid_in = 1; coeff_in = ld_data[b];
            @(posedge clk); #1;
        end
        #5;
        arst_n = 0;
        #1;
        checks++;
        if (write_en !== 1'b0 || busy !== 1'b0 || coeff_ready_out !== 1'b0 || addr !== '0 || done !== 1'b0) begin
            errors++;
            $display("FAIL midload_reset: we=%0b busy=%0b rdy=%0b addr=%0h done=%0b, required 0 0 0 0 0",
                     write_en, busy, coeff_ready_out, addr, done);
        end
        coeff_valid_in = 0;
        @(posedge clk); #1;
        arst_n = 1;
        nw = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (write_en) nw++;
        end
        checks++;
        if (nw != 0) begin errors++; $display("FAIL abandoned_load: got %0d writes, required 0", nw); end
        for (int k = 0; k < N; k++) ld_data[k] = CW'($urandom);
        run_load(0, 0, 0, -1);
        check_load(0, 0);
    endtask

    task automatic test_random();
        bit v;
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < N; k++) ld_data[k] = ($urandom_range(0, 3) == 0) ? '0 : CW'($urandom);
            corrupt = N'($urandom);
            v = 1'($urandom);
            run_load(v, $urandom_range(1, N-1), $urandom_range(0, 4), ($urandom_range(0, 1) == 1) ? 1 : -1);
            check_load(v, model_mismatch(v));
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gap();
        test_verify();
        test_corrupt();
        test_restart_ignored();
        test_reset_midload();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
